// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for register-register ALU instructions.
// Strobes decode from the state register and ir; T1 repeats until mem_ready, and clear aborts from any state.
module control_sequencer #(
    parameter logic [3:0] ALU_INC = 4'b1111,
    parameter logic [3:0] MUL_OP  = 4'b1010,
    parameter logic [3:0] DIV_OP  = 4'b1011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        PCout,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        Read,
    output logic [3:0]  ALUop,
    output logic [3:0]  step,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd15
    } state_t;

    state_t state_q, state_d;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_nop, is_halt, is_wide;
    logic       unused_ir_ok;

    assign op           = ir[31:27];
    assign ra           = ir[26:23];
    assign rb           = ir[22:19];
    assign rc           = ir[18:15];
    assign is_nop       = (op == 5'b11110);
    assign is_halt      = (op == 5'b11111);
    assign is_wide      = (op[3:0] == MUL_OP) || (op[3:0] == DIV_OP);
    assign unused_ir_ok = &{1'b0, ir[14:0]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = run ? S_T0 : S_IDLE;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = mem_ready ? S_T2 : S_T1;
            S_T2:    state_d = S_T3;
            S_T3: begin
                if (!op[4])       state_d = S_T4;
                else if (is_halt) state_d = S_HALT;
                else              state_d = S_T0;
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = is_wide ? S_T6 : S_T0;
            S_T6:    state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Each state drives at most one bus source, keeping the shared bus exclusive.
    always_comb begin
        Rin      = '0;
        Rout     = '0;
        PCin     = 1'b0;
        PCout    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Zlowin   = 1'b0;
        Zhighin  = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        Read     = 1'b0;
        ALUop    = '0;
        halted   = 1'b0;
        illegal  = 1'b0;
        unique case (state_q)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                ALUop  = ALU_INC;
                Zlowin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (!op[4]) begin
                    Rout = 16'h0001 << rb;
                    Yin  = 1'b1;
                end else if (!is_nop && !is_halt) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                Rout    = 16'h0001 << rc;
                ALUop   = op[3:0];
                Zlowin  = 1'b1;
                Zhighin = is_wide;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_wide) LOin = 1'b1;
                else         Rin  = 16'h0001 << ra;
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign step = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: expands each instruction into its expected per-cycle strobe trace.
module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic        pcin, pcout, marin, mdrin, mdrout, irin, yin, hiin, loin;
        logic        zlowin, zhighin, zlowout, zhighout, read;
        logic [3:0]  aluop;
        logic [3:0]  step;
        logic        halted, illegal;
    } ctl_t;

    logic        clock, clear, run, mem_ready;
    logic [31:0] ir;
    logic [15:0] Rin, Rout;
    logic        PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic        Zlowin, Zhighin, Zlowout, Zhighout, Read, halted, illegal;
    logic [3:0]  ALUop, step;
    ctl_t        obs;

    int n_checks = 0;
    int n_pass   = 0;
    ctl_t exp_q[$];

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .Read(Read), .ALUop(ALUop), .step(step),
        .halted(halted), .illegal(illegal)
    );

    assign obs = {Rin, Rout, PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, HIin, LOin,
                  Zlowin, Zhighin, Zlowout, Zhighout, Read, ALUop, step, halted, illegal};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, expv);
    endtask

    function automatic ctl_t blank(input logic [3:0] s);
        ctl_t c;
        c      = '0;
        c.step = s;
        return c;
    endfunction

    // Cycle-by-cycle trace of one instruction: fetch, wait cycles, then the class-specific tail.
    function automatic void build(input logic [31:0] instr, input int waits);
        ctl_t c;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        logic wide;
        op   = instr[31:27];
        ra   = instr[26:23];
        rb   = instr[22:19];
        rc   = instr[18:15];
        wide = (op[3:0] == 4'b1010) || (op[3:0] == 4'b1011);
        exp_q.delete();
        c = blank(1); c.pcout = 1; c.marin = 1; c.zlowin = 1; c.aluop = 4'b1111;
        exp_q.push_back(c);
        for (int k = 0; k <= waits; k++) begin
            c = blank(2); c.zlowout = 1; c.pcin = 1; c.read = 1; c.mdrin = 1;
            exp_q.push_back(c);
        end
        c = blank(3); c.mdrout = 1; c.irin = 1;
        exp_q.push_back(c);
        c = blank(4);
        if (!op[4]) begin
            c.rout = 16'(1 << rb); c.yin = 1;
            exp_q.push_back(c);
            c = blank(5); c.rout = 16'(1 << rc); c.aluop = op[3:0]; c.zlowin = 1; c.zhighin = wide;
            exp_q.push_back(c);
            c = blank(6); c.zlowout = 1;
            if (wide) c.loin = 1;
            else      c.rin  = 16'(1 << ra);
            exp_q.push_back(c);
            if (wide) begin
                c = blank(7); c.zhighout = 1; c.hiin = 1;
                exp_q.push_back(c);
            end
        end else begin
            c.illegal = (op != 5'b11110) && (op != 5'b11111);
            exp_q.push_back(c);
        end
    endfunction

    // abort_step = 0 runs to completion; otherwise clear is raised during that step.
    task automatic run_instr(input logic [31:0] instr, input int waits, input logic [3:0] abort_step);
        int t1_seen;
        ctl_t e;
        t1_seen = 0;
        build(instr, waits);
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            @(negedge clock);
            chk($sformatf("op%02h_s%0d", instr[31:27], e.step), 64'(obs), 64'(e));
            chk("bus_excl", 64'($countones({obs.rout, obs.pcout, obs.mdrout, obs.zlowout, obs.zhighout}) <= 1), 64'd1);
            if (e.step == abort_step) begin
                clear = 1'b1;
                return;
            end
            run       = 1'($urandom);
            mem_ready = 1'($urandom);
            if (e.step == 4'd2) begin
                mem_ready = (t1_seen == waits);
                t1_seen++;
            end
            if (e.step == 4'd1) ir = $urandom;
            if (e.step == 4'd3) ir = instr;
        end
    endtask

    task automatic expect_idle_and_restart(input string tag);
        @(negedge clock);
        chk(tag, 64'(obs), 64'(blank(0)));
        clear = 1'b0;
        run   = 1'b1;
    endtask

    logic [31:0] add_i, mul_i, div_i;
    ctl_t hc;

    initial begin
        clear = 1'b1; run = 1'b1; ir = '0; mem_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset", 64'(obs), 64'(blank(0)));
        clear = 1'b0; run = 1'b0;
        repeat (2) begin
            @(negedge clock);
            chk("idle_hold", 64'(obs), 64'(blank(0)));
        end
        run = 1'b1;

        add_i = {5'b00011, 4'd3, 4'd1, 4'd2, 15'b0};
        mul_i = {5'b01010, 4'd0, 4'd5, 4'd6, 15'b0};
        div_i = {5'b01011, 4'd7, 4'd7, 4'd7, 15'h1234};
        run_instr(add_i, 0, 4'd0);
        run_instr(add_i, 3, 4'd0);
        run_instr(mul_i, 1, 4'd0);
        run_instr(div_i, 0, 4'd0);
        run_instr({5'b10001, 27'h5a5a5a5}, 0, 4'd0);
        run_instr({5'b11110, 27'h0}, 2, 4'd0);
        run_instr({5'b00000, 4'd0, 4'd15, 4'd0, 15'h7fff}, 0, 4'd0);

        for (int n = 0; n < 40; n++) begin
            logic [4:0] rop;
            rop = 5'($urandom_range(0, 31));
            if (rop == 5'b11111) rop = 5'b11110;
            run_instr({rop, 27'($urandom)}, int'($urandom_range(0, 3)), 4'd0);
        end

        run_instr(add_i, 0, 4'd5);
        expect_idle_and_restart("clr_in_T4");
        run_instr(add_i, 3, 4'd2);
        expect_idle_and_restart("clr_in_T1");
        run_instr(mul_i, 0, 4'd0);

        run_instr({5'b11111, 27'h0}, 1, 4'd0);
        hc = blank(15);
        hc.halted = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("halt_hold", 64'(obs), 64'(hc));
            run       = 1'b1;
            mem_ready = 1'($urandom);
        end
        clear = 1'b1;
        expect_idle_and_restart("clr_from_halt");
        @(negedge clock);
        hc = blank(1); hc.pcout = 1; hc.marin = 1; hc.zlowin = 1; hc.aluop = 4'b1111;
        chk("restart_T0", 64'(obs), 64'(hc));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
